// File: rtl/mult_pkg.sv
// mult_pkg: shared types and widths for the multiplier front-end.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mult_pkg;

  localparam int OP_W        = 8;
  localparam int PROD_W      = 16;
  localparam int ACC_W       = 24;
  localparam int NOMINAL_LAT = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0] w;
    logic [OP_W-1:0] y;
  } op_t;

endpackage

// File: rtl/op_fifo.sv
// op_fifo: synchronous operand-pair FIFO with a fall-through head read.
// Latency: a pushed entry is visible at the head on the cycle after the push.
// Backpressure: a push is refused when full unless a pop frees a slot in the same cycle.
module op_fifo
  import mult_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic CLK,
  input  logic RESET,
  input  logic i_push,
  input  op_t  i_dat,
  input  logic i_pop,
  output op_t  o_dat,
  output logic o_full,
  output logic o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  op_t           r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_dat     = r_mem[r_rd_ptr];

  // Storage array; contents are meaningless until counted, so no reset.
  always_ff @(posedge CLK) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_dat;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mult_dispatcher.sv
// mult_dispatcher: buffers operand pairs, issues them to the multiplier, registers product and running sum.
// Latency: 13 cycles from push to out_valid with an empty pipe; one product per 12 cycles sustained.
// Backpressure: in_ready falls when the FIFO is full; a new pair is issued only once the output register is free.
module mult_dispatcher
  import mult_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_w,
  input  logic [OP_W-1:0]   in_y,
  output logic [OP_W-1:0]   mult_w,
  output logic [OP_W-1:0]   mult_y,
  output logic              mult_start,
  input  logic              mult_done,
  input  logic [PROD_W-1:0] mult_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_product,
  output logic [ACC_W-1:0]  out_acc,
  input  logic              acc_clr,
  output logic              err_timeout
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t              r_state;
  state_t              w_next;
  logic [TW-1:0]       r_cnt;
  logic [OP_W-1:0]     r_mult_w;
  logic [OP_W-1:0]     r_mult_y;
  logic                r_out_valid;
  logic [PROD_W-1:0]   r_product;
  logic [ACC_W-1:0]    r_acc;
  logic                r_err;
  logic                w_pop;
  logic                w_capture;
  logic                w_timeout;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  op_t                 w_head;
  op_t                 w_in_op;

  assign w_in_op     = '{w: in_w, y: in_y};
  assign in_ready    = !w_fifo_full;
  assign mult_start  = (r_state == ISSUE);
  assign mult_w      = r_mult_w;
  assign mult_y      = r_mult_y;
  assign out_valid   = r_out_valid;
  assign out_product = r_product;
  assign out_acc     = r_acc;
  assign err_timeout = r_err;

  op_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK     (CLK),
    .RESET   (RESET),
    .i_push  (in_valid && in_ready),
    .i_dat   (w_in_op),
    .i_pop   (w_pop),
    .o_dat   (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next state; done pulses only matter in WAIT (and end HOLD early).
  always_comb begin
    w_next    = r_state;
    w_pop     = 1'b0;
    w_capture = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_fifo_empty && (!r_out_valid || out_ready)) begin
          w_pop  = 1'b1;
          w_next = ISSUE;
        end
      end
      ISSUE: w_next = WAIT;
      WAIT: begin
        if (mult_done) begin
          w_capture = 1'b1;
          w_next    = IDLE;
        end else if (r_cnt == TW'(TIMEOUT - 1)) begin
          w_timeout = 1'b1;
          w_next    = HOLD;
        end
      end
      HOLD: begin
        if (mult_done || (r_cnt == TW'(1))) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Cycle counter: restarts on every state change, counts only in WAIT/HOLD.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                                     r_cnt <= '0;
    else if (w_next != r_state)                    r_cnt <= '0;
    else if ((r_state == WAIT) || (r_state == HOLD)) r_cnt <= r_cnt + 1'b1;
  end

  // Operands change only when a pair is popped; the multiplier reads them live.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_mult_w <= '0;
      r_mult_y <= '0;
    end else if (w_pop) begin
      r_mult_w <= w_head.w;
      r_mult_y <= w_head.y;
    end
  end

  // Output register; a new capture or timeout record beats the handshake clear.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_out_valid <= 1'b0;
      r_product   <= '0;
    end else if (w_capture) begin
      r_out_valid <= 1'b1;
      r_product   <= mult_result;
    end else if (w_timeout) begin
      r_out_valid <= 1'b1;
      r_product   <= '0;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Accumulator; a clear coinciding with a capture restarts the sum at that product.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)          r_acc <= '0;
    else if (w_capture) r_acc <= (acc_clr ? '0 : r_acc) + ACC_W'(mult_result);
    else if (acc_clr)   r_acc <= '0;
  end

  // Sticky timeout flag.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)          r_err <= 1'b0;
    else if (w_timeout) r_err <= 1'b1;
  end

endmodule

// File: tb/tb_mult_dispatcher.sv
module tb_mult_dispatcher;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_w = '0;
  logic [7:0]  in_y = '0;
  logic [7:0]  mult_w;
  logic [7:0]  mult_y;
  logic        mult_start;
  logic        mult_done;
  logic [15:0] mult_result;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_product;
  logic [23:0] out_acc;
  logic        acc_clr = 1'b0;
  logic        err_timeout;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  mult_dispatcher #(.FIFO_DEPTH(4), .TIMEOUT(16)) dut (
    .CLK(CLK), .RESET(RESET),
    .in_valid(in_valid), .in_ready(in_ready), .in_w(in_w), .in_y(in_y),
    .mult_w(mult_w), .mult_y(mult_y), .mult_start(mult_start),
    .mult_done(mult_done), .mult_result(mult_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .out_acc(out_acc),
    .acc_clr(acc_clr), .err_timeout(err_timeout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Behavioural multiplier: done sampled 'lat' edges after start is sampled.
  int   lat = 10;
  bit   never = 1'b0;
  int   mcnt = 0;
  logic m_done = 1'b0;
  logic inj_done = 1'b0;
  logic prev_start = 1'b0;
  int   start_cnt = 0;

  assign mult_done   = m_done | inj_done;
  assign mult_result = mult_done ? ({8'd0, mult_w} * {8'd0, mult_y}) : 16'hDEAD;

  always @(negedge CLK or posedge RESET) begin
    if (RESET) begin
      mcnt = 0; m_done = 1'b0; prev_start = 1'b0;
    end else begin
      m_done = 1'b0;
      if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) m_done = 1'b1;
      end
      if (mult_start) begin
        start_cnt++;
        chk("start_single_cycle", {31'd0, prev_start}, 0);
        if (!never) mcnt = lat;
      end
      prev_start = mult_start;
    end
  end

  // Scoreboard: expected products in push order, running sum mod 2^24.
  int          exp_q[$];
  logic [23:0] acc_model = '0;
  bit          mon_en = 1'b0;

  always @(negedge CLK) begin
    int p;
    if (RESET) begin
      exp_q.delete();
      acc_model = '0;
    end else if (mon_en) begin
      if (in_valid && in_ready) exp_q.push_back(int'(in_w) * int'(in_y));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("sb_unexpected_output", 1, 0);
        else begin
          p = exp_q.pop_front();
          acc_model = acc_model + 24'(p);
          chk("sb_product", {16'd0, out_product}, p);
          chk("sb_acc", {8'd0, out_acc}, {8'd0, acc_model});
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1; in_valid = 1'b0; out_ready = 1'b0; acc_clr = 1'b0; inj_done = 1'b0;
    never = 1'b0; lat = 10;
    repeat (2) tick();
    RESET = 1'b0;
    tick();
  endtask

  task automatic push(input logic [7:0] w, input logic [7:0] y);
    bit ok = 1'b0;
    in_w = w; in_y = y; in_valid = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(negedge CLK); ok = in_ready;
      @(posedge CLK); #1;
      if (ok) break;
    end
    in_valid = 1'b0;
    chk("push_accepted", {31'd0, ok}, 1);
  endtask

  task automatic wait_valid(input int bound, output int n);
    n = 0;
    while (!out_valid && n < bound) begin tick(); n++; end
    chk("out_valid_arrived", {31'd0, out_valid}, 1);
  endtask

  task automatic drain(input int bound);
    int k = 0;
    while (exp_q.size() != 0 && k < bound) begin tick(); k++; end
    tick();
    chk("scoreboard_drained", exp_q.size(), 0);
  endtask

  typedef struct {
    logic [7:0] w;
    logic [7:0] y;
    int         lat;
    int         prod;
  } vec_t;

  vec_t tbl [8];
  bit   push_done;

  initial begin
    int m, s0;
    logic [23:0] acc_exp;
    bit found;

    tbl[0] = '{8'd3,   8'd5,   10, 15};
    tbl[1] = '{8'd0,   8'd0,   10, 0};
    tbl[2] = '{8'd255, 8'd255, 10, 65025};
    tbl[3] = '{8'd1,   8'd255, 12, 255};
    tbl[4] = '{8'd128, 8'd2,   16, 256};
    tbl[5] = '{8'd15,  8'd17,  11, 255};
    tbl[6] = '{8'd200, 8'd100, 13, 20000};
    tbl[7] = '{8'd255, 8'd1,   16, 255};

    // Reset values while RESET is held.
    tick();
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_mult_start", {31'd0, mult_start}, 0);
    chk("rst_mult_w", {24'd0, mult_w}, 0);
    chk("rst_mult_y", {24'd0, mult_y}, 0);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_product", {16'd0, out_product}, 0);
    chk("rst_out_acc", {8'd0, out_acc}, 0);
    chk("rst_err", {31'd0, err_timeout}, 0);

    // Single operation.
    do_reset();
    mon_en = 1'b1;
    s0 = start_cnt;
    push(8'd3, 8'd5);
    wait_valid(40, m);
    chk("single_latency", 1 + m, 13);
    chk("single_product", {16'd0, out_product}, 15);
    chk("single_acc", {8'd0, out_acc}, 15);
    chk("single_starts", start_cnt - s0, 1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("single_valid_cleared", {31'd0, out_valid}, 0);

    // Burst under back-pressure.
    do_reset();
    mon_en = 1'b1;
    s0 = start_cnt;
    push(8'd255, 8'd255); push(8'd16, 8'd16); push(8'd0, 8'd7);
    repeat (30) tick();
    chk("burst_in_ready", {31'd0, in_ready}, 1);
    chk("burst_valid_held", {31'd0, out_valid}, 1);
    chk("burst_first_product", {16'd0, out_product}, 65025);
    chk("burst_second_delayed", start_cnt - s0, 1);
    out_ready = 1'b1;
    drain(200);
    chk("burst_acc", {8'd0, out_acc}, 65281);
    chk("burst_starts", start_cnt - s0, 3);
    chk("burst_valid_idle", {31'd0, out_valid}, 0);

    // FIFO full with a slow multiplier.
    do_reset();
    mon_en = 1'b1; lat = 14; out_ready = 1'b1;
    s0 = start_cnt;
    for (int i = 0; i < 5; i++) push(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    chk("full_in_ready_low", {31'd0, in_ready}, 0);
    push(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    drain(400);
    chk("full_starts", start_cnt - s0, 6);

    // Timeout, late pulse in HOLD, then normal recovery.
    do_reset();
    mon_en = 1'b0; never = 1'b1;
    push(8'd3, 8'd4);
    repeat (17) tick();
    chk("to_err_before", {31'd0, err_timeout}, 0);
    tick();
    chk("to_err_set", {31'd0, err_timeout}, 1);
    chk("to_valid", {31'd0, out_valid}, 1);
    chk("to_product_zero", {16'd0, out_product}, 0);
    chk("to_acc_kept", {8'd0, out_acc}, 0);
    inj_done = 1'b1; tick(); inj_done = 1'b0;
    chk("to_late_product", {16'd0, out_product}, 0);
    chk("to_late_acc", {8'd0, out_acc}, 0);
    never = 1'b0;
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("to_record_consumed", {31'd0, out_valid}, 0);
    push(8'd6, 8'd7);
    wait_valid(40, m);
    chk("to_next_latency", 1 + m, 13);
    chk("to_next_product", {16'd0, out_product}, 42);
    chk("to_next_acc", {8'd0, out_acc}, 42);
    chk("to_err_sticky", {31'd0, err_timeout}, 1);

    // Accumulator: sixteen maximal products, then clear coinciding with a capture.
    do_reset();
    mon_en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) push(8'd255, 8'd255);
    drain(600);
    chk("acc_sixteen", {8'd0, out_acc}, 1040400);
    mon_en = 1'b0;
    push(8'd2, 8'd2);
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK); #1;
      if (mult_done) begin found = 1'b1; break; end
    end
    chk("acc_done_seen", {31'd0, found}, 1);
    acc_clr = 1'b1; @(posedge CLK); #1; acc_clr = 1'b0;
    chk("acc_clr_capture", {8'd0, out_acc}, 4);
    chk("acc_clr_product", {16'd0, out_product}, 4);
    tick();
    acc_clr = 1'b1; tick(); acc_clr = 1'b0;
    chk("acc_clr_alone", {8'd0, out_acc}, 0);

    // Asynchronous reset in the middle of WAIT.
    push(8'd9, 8'd9);
    wait_valid(40, m);
    tick();
    chk("mid_pre_acc", {8'd0, out_acc}, 81);
    out_ready = 1'b0;
    push(8'd5, 8'd5); push(8'd7, 8'd7);
    repeat (6) tick();
    #3 RESET = 1'b1;
    #1;
    chk("mid_out_valid", {31'd0, out_valid}, 0);
    chk("mid_out_product", {16'd0, out_product}, 0);
    chk("mid_out_acc", {8'd0, out_acc}, 0);
    chk("mid_in_ready", {31'd0, in_ready}, 1);
    chk("mid_mult_w", {24'd0, mult_w}, 0);
    chk("mid_mult_start", {31'd0, mult_start}, 0);
    @(posedge CLK); #1; RESET = 1'b0;
    s0 = start_cnt;
    inj_done = 1'b1; tick(); inj_done = 1'b0;
    repeat (20) tick();
    chk("mid_stale_done", {31'd0, out_valid}, 0);
    chk("mid_fifo_empty", start_cnt - s0, 0);

    // Table of single operations, including done on the last allowed WAIT cycle.
    do_reset();
    mon_en = 1'b0;
    acc_exp = '0;
    for (int i = 0; i < 8; i++) begin
      lat = tbl[i].lat;
      push(tbl[i].w, tbl[i].y);
      wait_valid(60, m);
      acc_exp = acc_exp + 24'(tbl[i].prod);
      chk("tbl_latency", 1 + m, 3 + tbl[i].lat);
      chk("tbl_product", {16'd0, out_product}, tbl[i].prod);
      chk("tbl_acc", {8'd0, out_acc}, {8'd0, acc_exp});
      chk("tbl_no_timeout", {31'd0, err_timeout}, 0);
      out_ready = 1'b1; tick(); out_ready = 1'b0;
    end
    lat = 10;

    // Randomized traffic against the scoreboard.
    do_reset();
    mon_en = 1'b1;
    s0 = start_cnt;
    push_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          lat = $urandom_range(10, 15);
          push(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
          repeat ($urandom_range(0, 3)) tick();
        end
        push_done = 1'b1;
      end
      begin
        while (!push_done) begin
          out_ready = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    out_ready = 1'b1;
    drain(2000);
    chk("rand_starts", start_cnt - s0, 40);
    chk("rand_no_timeout", {31'd0, err_timeout}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got %0d miscompares so far, expected completion", n_err);
    $fatal(1);
  end

endmodule

// File: doc/mult_dispatcher.md
# mult_dispatcher

Front-end sequencer for the 8-bit multiplier. Accepts a stream of operand pairs over a valid/ready interface and buffers them in a small FIFO. Issues each pair to the multiplier with a one-cycle start pulse, waits for its done pulse, then registers the 16-bit product and a running 24-bit accumulation for a downstream valid/ready consumer.

## Interface
- FIFO_DEPTH, default 4: operand FIFO entries; power of two, 2..16.
- TIMEOUT, default 16: maximum cycles in WAIT before the error flag is raised; must be ≥ 12.
- CLK  in  1  clock; all logic is posedge.
- RESET  in  1  reset; asynchronous, active-high.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  FIFO not full.
- in_w, in_y  in  8 each  multiplicand and multiplier.
- mult_w, mult_y  out  8 each  operands driven to the multiplier.
- mult_start  out  1  start pulse to the multiplier (its S).
- mult_done  in  1  multiplier done pulse (its PRONTO).
- mult_result  in  16  multiplier product; valid while mult_done=1.
- out_valid  out  1  product register holds data.
- out_ready  in  1  consumer accepts.
- out_product  out  16  registered product.
- out_acc  out  24  running sum of products, including the one presented.
- acc_clr  in  1  synchronous accumulator clear.
- err_timeout  out  1  sticky; set when mult_done does not arrive in time.

## Operation
- **FIFO push.** A push occurs when in_valid && in_ready. in_ready = !full.
- **Simultaneous push and pop.** Allowed when the FIFO is full.
- **Full FIFO.** Offers are not taken. Data is never overwritten.
- **FSM states (2-bit):** IDLE, ISSUE, WAIT, HOLD.
- **IDLE.**
  - Condition: FIFO not empty and (!out_valid or out_ready this cycle).
  - Action: pop the head, latch it into mult_w/mult_y, go to ISSUE.
- **ISSUE.** mult_start=1 for exactly this cycle, then go to WAIT.
- **WAIT.**
  - Operands are held constant; the multiplier reads them live, not latched.
  - On mult_done=1: capture mult_result into out_product, set out_acc ← out_acc + mult_result (mod 2^24), set out_valid=1, go to IDLE.
  - If the wait counter reaches TIMEOUT first: set err_timeout, load out_product=0, leave out_acc unchanged, set out_valid=1, go to HOLD.
- **HOLD.**
  - Entered only after a timeout.
  - Exits to IDLE when mult_done is seen, or after 2 further cycles, to flush a late pulse.
- **Stray done pulses.** mult_done is ignored in IDLE and ISSUE. This covers an undefined PRONTO after power-up and late pulses.
- **Output handshake.** out_valid clears on out_ready && out_valid unless a new capture occurs in the same cycle; a capture in that cycle wins.
- **acc_clr.**
  - Without a capture in the same cycle: out_acc ← 0.
  - With a capture in the same cycle: out_acc ← mult_result.
- **err_timeout.** Cleared only by RESET.
- **Reset values:** in_ready=1, mult_start=0, mult_w=mult_y=0, out_valid=0, out_product=0, out_acc=0, err_timeout=0, FSM=IDLE, FIFO empty.
- **RESET mid-operation.** The in-flight pair and the FIFO contents are discarded. The multiplier shares RESET, so both restart clean.

## Timing
- **Multiplier response.** mult_done arrives nominally 10 cycles after mult_start is sampled (a single-cycle pulse).
- **Push to out_valid.** With an empty pipe, a push at edge 0 gives out_valid at edge 13: 1 FIFO cycle, 1 IDLE, 1 ISSUE, 10 WAIT.
- **Throughput.** One product per 12 cycles with out_ready held high.
- **mult_start timing.** mult_start is never asserted while the FSM is outside ISSUE, so there are never back-to-back starts.
- **Operand stability.** mult_w/mult_y change only on the IDLE→ISSUE edge.
- **in_ready.** Combinational from the FIFO count only; it does not depend on in_valid.

## Structure
- **Package mult_pkg:**
  - state enum (IDLE=0, ISSUE=1, WAIT=2, HOLD=3);
  - OP_W=8, PROD_W=16, ACC_W=24;
  - NOMINAL_LAT=10.
- **Sub-module op_fifo.** Synchronous FIFO, 16-bit entries ({w,y}), with DEPTH parameter, count, full and empty, and asynchronous RESET.
- **Top level.** FSM, wait counter, output and accumulator registers. The multiplier is instantiated outside this block.

## Test plan
- **Single operation.** Push w=3, y=5 with a behavioural multiplier model (latency 10) → out_product=15, out_acc=15, out_valid at cycle 13, mult_start high for exactly 1 cycle.
- **Burst with back-pressure.**
  - Stimulus: push 255×255, 16×16, 0×7; hold out_ready=0 for 30 cycles.
  - Response: in_ready still 1. Second issue is delayed until the first product is accepted. Products arrive as 65025, 256, 0; out_acc reaches 65281.
- **FIFO full.**
  - Stimulus: push 6 pairs back-to-back while the multiplier is stalled.
  - Response: in_ready drops after FIFO_DEPTH entries plus the one in flight. No pair is lost or duplicated (scoreboard).
- **Timeout.**
  - Stimulus: a model that never asserts mult_done.
  - Response: err_timeout=1 at cycle 16 of WAIT; out_product=0 with out_valid=1; a late done pulse in HOLD is ignored; the next pair completes normally.
- **Accumulator.**
  - Stimulus: sixteen 255×255 operations, then acc_clr in the same cycle as a 2×2 capture.
  - Response: out_acc=1,040,400 (1,040,400 < 2^24, no wrap occurs); after the clear, out_acc=4.
- **Reset mid-WAIT.** Assert RESET asynchronously → all outputs return to reset values immediately, FIFO is empty, and the stale done pulse is ignored.
